aes_round_ctrl_wddl: RTL and testbench

Round sequencer for the WDDL dual-rail AES-128 encryption core. It accepts a plaintext through a ready/start handshake and registers it as complementary rails for the AddRoundKey stage. It then generates the `ld_r` load strobe, the key-schedule strobes and the round index. It also inserts WDDL precharge cycles between evaluate cycles and flags completion. It sits between the core top level and the AddRoundKey, SubBytes/ShiftRows/MixColumns and key-expansion datapath.

---
 rtl/aes_wddl_pkg.sv | 15 +
 rtl/aes_dreg_wddl.sv | 30 +++
 rtl/aes_round_ctrl_wddl.sv | 106 ++++++++++
 tb/tb_aes_round_ctrl_wddl.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_wddl_pkg.sv
// Shared types and constants for the WDDL dual-rail AES-128 round control.
package aes_wddl_pkg;

  localparam int unsigned AES128_NR = 10;
  localparam int unsigned RoundW    = 4;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StPre,
    StEval,
    StDone
  } state_e;

endpackage

// File: rtl/aes_dreg_wddl.sv
// Dual-rail capture register: loads true and complement rails together on enable,
// and clears both rails low (the precharged state) on reset.
module aes_dreg_wddl #(
  parameter int unsigned Width = 128
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_en,
  input  logic [Width-1:0] i_d,
  output logic [Width-1:0] o_q,
  output logic [Width-1:0] o_q_n
);

  logic [Width-1:0] r_q;
  logic [Width-1:0] r_q_n;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_q   <= '0;
      r_q_n <= '0;
    end else if (i_en) begin
      r_q   <= i_d;
      r_q_n <= ~i_d;
    end
  end

  assign o_q   = r_q;
  assign o_q_n = r_q_n;

endmodule

// File: rtl/aes_round_ctrl_wddl.sv
// Round sequencer for the WDDL AES-128 core: start handshake, dual-rail plaintext
// capture, load/key strobes, round index and optional precharge cycles.
module aes_round_ctrl_wddl
  import aes_wddl_pkg::*;
#(
  parameter int unsigned NR        = AES128_NR,
  parameter int unsigned PRECHARGE = 1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_ld,
  input  logic [127:0]      i_text_in,
  output logic              o_ready,
  output logic [127:0]      o_text_in_r,
  output logic [127:0]      o_text_in_r_n,
  output logic              o_ld_r,
  output logic              o_kld,
  output logic              o_key_adv,
  output logic              o_pre,
  output logic [RoundW-1:0] o_round,
  output logic              o_last_round,
  output logic              o_done
);

  localparam logic [RoundW-1:0] NrW = RoundW'(NR);
  localparam logic              UsePre = (PRECHARGE != 0);

  state_e            r_state;
  state_e            w_state_d;
  logic [RoundW-1:0] r_round;
  logic [RoundW-1:0] w_round_d;
  logic              w_accept;
  logic              w_final;

  assign w_final  = (r_round == NrW);
  assign w_accept = i_ld & ((r_state == StIdle) | (r_state == StDone));

  always_comb begin
    w_state_d = r_state;
    w_round_d = r_round;
    unique case (r_state)
      StIdle: begin
        if (i_ld) begin
          w_state_d = StLoad;
          w_round_d = '0;
        end
      end
      StLoad: begin
        w_state_d = UsePre ? StPre : StEval;
        w_round_d = RoundW'(1);
      end
      StPre: begin
        w_state_d = StEval;
      end
      StEval: begin
        if (w_final) begin
          w_state_d = StDone;
        end else begin
          w_state_d = UsePre ? StPre : StEval;
          w_round_d = r_round + 1'b1;
        end
      end
      StDone: begin
        // Back-to-back start skips IDLE entirely.
        w_state_d = i_ld ? StLoad : StIdle;
        w_round_d = '0;
      end
      default: begin
        w_state_d = StIdle;
        w_round_d = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= StIdle;
      r_round <= '0;
    end else begin
      r_state <= w_state_d;
      r_round <= w_round_d;
    end
  end

  aes_dreg_wddl #(
    .Width(128)
  ) u_text_reg (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_en  (w_accept),
    .i_d   (i_text_in),
    .o_q   (o_text_in_r),
    .o_q_n (o_text_in_r_n)
  );

  // Every strobe is a pure decode of the state register.
  assign o_ready      = (r_state == StIdle) | (r_state == StDone);
  assign o_ld_r       = (r_state == StLoad);
  assign o_kld        = (r_state == StLoad);
  assign o_pre        = (r_state == StPre);
  assign o_key_adv    = (r_state == StEval);
  assign o_done       = (r_state == StDone);
  assign o_round      = r_round;
  assign o_last_round = ((r_state == StPre) | (r_state == StEval)) & w_final;

endmodule

// File: tb/tb_aes_round_ctrl_wddl.sv
// Directed bench for aes_round_ctrl_wddl: three instances (NR=10 with and without
// precharge, NR=1 with precharge) share clock, reset and start inputs.
module tb_aes_round_ctrl_wddl;

  localparam logic [127:0] T1 = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] T2 = 128'h00112233445566778899aabbccddeeff;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         ld = 1'b0;
  logic [127:0] text_in = '0;

  logic         a_ready, a_ldr, a_kld, a_kadv, a_pre, a_last, a_done;
  logic [127:0] a_tr, a_trn;
  logic [3:0]   a_round;
  logic         b_ready, b_ldr, b_kld, b_kadv, b_pre, b_last, b_done;
  logic [127:0] b_tr, b_trn;
  logic [3:0]   b_round;
  logic         c_ready, c_ldr, c_kld, c_kadv, c_pre, c_last, c_done;
  logic [127:0] c_tr, c_trn;
  logic [3:0]   c_round;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  aes_round_ctrl_wddl #(.NR(10), .PRECHARGE(1)) u_a (
    .i_clk(clk), .i_rst(rst), .i_ld(ld), .i_text_in(text_in),
    .o_ready(a_ready), .o_text_in_r(a_tr), .o_text_in_r_n(a_trn), .o_ld_r(a_ldr),
    .o_kld(a_kld), .o_key_adv(a_kadv), .o_pre(a_pre), .o_round(a_round),
    .o_last_round(a_last), .o_done(a_done)
  );

  aes_round_ctrl_wddl #(.NR(10), .PRECHARGE(0)) u_b (
    .i_clk(clk), .i_rst(rst), .i_ld(ld), .i_text_in(text_in),
    .o_ready(b_ready), .o_text_in_r(b_tr), .o_text_in_r_n(b_trn), .o_ld_r(b_ldr),
    .o_kld(b_kld), .o_key_adv(b_kadv), .o_pre(b_pre), .o_round(b_round),
    .o_last_round(b_last), .o_done(b_done)
  );

  aes_round_ctrl_wddl #(.NR(1), .PRECHARGE(1)) u_c (
    .i_clk(clk), .i_rst(rst), .i_ld(ld), .i_text_in(text_in),
    .o_ready(c_ready), .o_text_in_r(c_tr), .o_text_in_r_n(c_trn), .o_ld_r(c_ldr),
    .o_kld(c_kld), .o_key_adv(c_kadv), .o_pre(c_pre), .o_round(c_round),
    .o_last_round(c_last), .o_done(c_done)
  );

  task automatic do_reset();
    rst = 1'b1;
    ld  = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  // Samples A's outputs while reset is applied and compares against reset values.
  task automatic check_a_reset(input string tag);
    logic [9:0] got;
    got = {a_pre, a_kadv, a_done, a_ldr, a_kld, a_ready, a_last, 3'b000};
    n_cmp++;
    if (got !== 10'b0000010000 || a_round !== 4'd0) begin
      n_err++;
      $display("FAIL %s ctrl got=%b round=%0d exp=0000010000 round=0", tag, got, a_round);
    end
    n_cmp++;
    if (a_tr !== 128'd0 || a_trn !== 128'd0) begin
      n_err++;
      $display("FAIL %s rails got=%h/%h exp=0/0", tag, a_tr, a_trn);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1;
    check_a_reset("reset_a");
    n_cmp++;
    if ({b_ready, b_done, b_pre, c_ready, c_done, c_pre, c_last} !== 7'b1001000) begin
      n_err++;
      $display("FAIL reset_bc got=%b exp=1001000",
               {b_ready, b_done, b_pre, c_ready, c_done, c_pre, c_last});
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_a_reset("idle_a");
  endtask

  task automatic test_sequence();
    logic [6:0] exp_a, got_a;
    logic [3:0] exp_b, got_b;
    logic [5:0] exp_c, got_c;
    int kadv_cnt;
    kadv_cnt = 0;
    do_reset();
    text_in = T1;
    ld = 1'b1;
    for (int c = 1; c <= 23; c++) begin
      @(negedge clk);
      if (a_kadv) kadv_cnt++;
      // {pre, key_adv, done, ld_r, kld, ready, last_round}
      exp_a = {(c >= 2 && c <= 21 && c % 2 == 0), (c >= 3 && c <= 21 && c % 2 == 1),
               (c == 22), (c == 1), (c == 1), (c >= 22), (c == 20 || c == 21)};
      got_a = {a_pre, a_kadv, a_done, a_ldr, a_kld, a_ready, a_last};
      n_cmp++;
      if (got_a !== exp_a) begin
        n_err++;
        $display("FAIL seq_a cyc=%0d got=%b exp=%b", c, got_a, exp_a);
      end
      if (c <= 21) begin
        n_cmp++;
        if (a_round !== ((c == 1) ? 4'd0 : 4'((c - 2) / 2 + 1))) begin
          n_err++;
          $display("FAIL round_a cyc=%0d got=%0d", c, a_round);
        end
      end
      exp_b = {1'b0, (c >= 2 && c <= 11), (c == 12), (c >= 12)};
      got_b = {b_pre, b_kadv, b_done, b_ready};
      n_cmp++;
      if (got_b !== exp_b) begin
        n_err++;
        $display("FAIL seq_b cyc=%0d got=%b exp=%b", c, got_b, exp_b);
      end
      if (c <= 5) begin
        exp_c = {(c == 1), (c == 2), (c == 3), (c == 4), (c == 2 || c == 3), (c >= 4)};
        got_c = {c_ldr, c_pre, c_kadv, c_done, c_last, c_ready};
        n_cmp++;
        if (got_c !== exp_c) begin
          n_err++;
          $display("FAIL seq_c cyc=%0d got=%b exp=%b", c, got_c, exp_c);
        end
      end
      if (c == 1 || c == 21) begin
        n_cmp++;
        if (a_tr !== T1 || a_trn !== ~T1) begin
          n_err++;
          $display("FAIL rails_a cyc=%0d got=%h/%h exp=%h/%h", c, a_tr, a_trn, T1, ~T1);
        end
      end
      // Stray start pulse during the rounds must be ignored by A and B.
      if (c == 1) begin
        ld = 1'b0;
        text_in = T2;
      end
      if (c == 5) ld = 1'b1;
      if (c == 6) ld = 1'b0;
    end
    n_cmp++;
    if (kadv_cnt != 10) begin
      n_err++;
      $display("FAIL kadv_count got=%0d exp=10", kadv_cnt);
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] exp_a, got_a;
    int cc, done_cnt;
    done_cnt = 0;
    do_reset();
    text_in = T1;
    ld = 1'b1;
    for (int c = 1; c <= 44; c++) begin
      @(negedge clk);
      if (a_done) done_cnt++;
      cc = (c <= 22) ? c : c - 22;
      exp_a = {(cc >= 2 && cc <= 21 && cc % 2 == 0), (cc == 22), (cc == 1),
               (cc >= 3 && cc <= 21 && cc % 2 == 1)};
      got_a = {a_pre, a_done, a_ldr, a_kadv};
      n_cmp++;
      if (got_a !== exp_a) begin
        n_err++;
        $display("FAIL b2b_a cyc=%0d got=%b exp=%b", c, got_a, exp_a);
      end
      if (c == 11 || c == 23) begin
        n_cmp++;
        if (a_tr !== ((c == 11) ? T1 : T2) || a_trn !== ~((c == 11) ? T1 : T2)) begin
          n_err++;
          $display("FAIL b2b_rails cyc=%0d got=%h/%h", c, a_tr, a_trn);
        end
      end
      if (c == 10) text_in = T2;
      if (c == 44) ld = 1'b0;
    end
    n_cmp++;
    if (done_cnt != 2) begin
      n_err++;
      $display("FAIL b2b_done_count got=%0d exp=2", done_cnt);
    end
  endtask

  task automatic test_mid_reset();
    int done_cnt;
    done_cnt = 0;
    do_reset();
    text_in = T1;
    ld = 1'b1;
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      if (c == 1) ld = 1'b0;
    end
    rst = 1'b1;
    #1;
    check_a_reset("midrst");
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (a_done || !a_ready) done_cnt++;
    end
    n_cmp++;
    if (done_cnt != 0) begin
      n_err++;
      $display("FAIL midrst_quiet got=%0d busy/done cycles exp=0", done_cnt);
    end
    text_in = T2;
    ld = 1'b1;
    for (int c = 1; c <= 22; c++) begin
      @(negedge clk);
      if (c == 1) begin
        ld = 1'b0;
        n_cmp++;
        if (a_ldr !== 1'b1 || a_tr !== T2 || a_trn !== ~T2) begin
          n_err++;
          $display("FAIL restart_load got=%b %h exp=1 %h", a_ldr, a_tr, T2);
        end
      end
      n_cmp++;
      if (a_done !== (c == 22)) begin
        n_err++;
        $display("FAIL restart_done cyc=%0d got=%b exp=%b", c, a_done, (c == 22));
      end
    end
  endtask

  initial begin
    test_reset();
    test_sequence();
    test_back_to_back();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
